pe_mac: RTL and testbench
=========================

# pe_mac

Parametrised multiply-accumulate processing element, the next generation of the array's single-tap PE. Each accepted beat selects one of three feature sources, multiplies it by a signed weight and accumulates it into a window of `TAPS` products. The block emits one accumulated result per window with a valid pulse, and sits between the feature-routing fabric and the array's output collector.

## Interface
- `DW`, 8: feature width (signed).
- `WW`, 8: weight width (signed).
- `AW`, 20: accumulator/result width (signed); must be ≥ DW+WW.
- `TAPS`, 9: products per accumulation window; must be ≥ 1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset (assert on low, release synchronously to `clk`).
- `en`  in  1  global enable; 0 stalls the whole block.
- `clear`  in  1  synchronous flush of the pipeline, tap counter and accumulator.
- `in_valid`  in  1  beat qualifier for `control`, `fi`, `frv`, `fot`, `wi`.
- `control`  in  2  feature select: 0 = zero, 1 = `fi`, 2 = `fot`, 3 = `frv`.
- `fi`, `fot`, `frv`  in  DW each  feature sources, two's complement.
- `wi`  in  WW  signed weight.
- `acc_out`  out  AW  signed window result.
- `out_valid`  out  1  one-cycle pulse marking a new `acc_out`.
- `ovf`  out  1  set with `out_valid` if the window saturated.

## Operation
- Pipeline stages, each advancing only when `en`=1:
  - S1 registers the selected feature `f`, `wi`, the beat valid and a last-tap flag.
  - S2 registers the full-precision signed product (DW+WW bits).
  - S3 accumulates.
- A beat is accepted when `in_valid`=1, `en`=1 and `clear`=0.
- `control`=0 still counts as a tap, contributing 0.
- A tap counter runs 0..TAPS-1 over accepted beats and wraps to 0 after TAPS-1. The beat at count TAPS-1 is tagged last.
- On S3 for a first-in-window beat, the accumulator loads the sign-extended product; otherwise it adds the product to the accumulator.
- On S3 for a last beat:
  - `acc_out` ← final sum; `out_valid` pulses 1.
  - `ovf` ← the window's sticky overflow.
  - The next window starts fresh with no bubble.
- Arithmetic: the sum is computed in AW+1 bits. Out-of-range handling is set by the configuration macro.
- `en`=0: every register holds, including `acc_out`, `out_valid` and `ovf`, and `in_valid` is ignored. Consumers sample results on `out_valid && en`.
- `clear`=1 (priority over `en`):
  - In-flight beats are discarded; tap counter, accumulator, sticky overflow and `out_valid` are zeroed.
  - `acc_out` holds its last value.
- Reset values: `acc_out`=0, `out_valid`=0, `ovf`=0; counter, accumulator and all stage registers 0.

## Timing
- Latency: the last beat accepted at edge t gives `out_valid`=1 after edge t+3, counting enabled edges only.
- Throughput: one beat per enabled cycle; one result every TAPS beats.
- Back-to-back windows: `out_valid` pulses exactly every TAPS accepted beats.
- `en` low for N cycles mid-stream delays the output by exactly N cycles with the value unchanged.
- `rst` asserted mid-window: all state is lost immediately, with no partial result.
- TAPS=1: every accepted beat produces a result.

## Configuration
- `PE_SAT_EN` defined:
  - Accumulation saturates to [-2^(AW-1), 2^(AW-1)-1].
  - Any clamp in a window sets the sticky flag, reported on `ovf`.
- `PE_SAT_EN` undefined:
  - Accumulation wraps modulo 2^AW.
  - `ovf` is tied 0.

## Test plan
- Reset/idle: hold `rst`=0 then release, no `in_valid` → `acc_out`=0, `out_valid`=0, `ovf`=0 indefinitely.
- Basic window, TAPS=4: beats (`control`=1, `fi`=3, `wi`=2), (`control`=2, `fot`=-5, `wi`=4), (`control`=3, `frv`=7, `wi`=-1), (`control`=0, `wi`=9) → one `out_valid` 3 cycles after the 4th beat, `acc_out`=-21, `ovf`=0.
- Continuous stream, TAPS=4: `fi`=1, `wi`=1, 12 consecutive beats → 3 pulses spaced 4 cycles apart, each `acc_out`=4.
- Stall: same as the basic window, with `en`=0 for 5 cycles after beat 2 → same -21, delivered exactly 5 cycles later, no duplicate pulse counted.
- Clear: assert `clear` after 2 beats, then send 4 beats of `fi`=2, `wi`=3 → single result 24.
- Overflow, AW=16, TAPS=4, four beats of `fi`=-128, `wi`=-128:
  - With `PE_SAT_EN`: `acc_out`=32767, `ovf`=1.
  - Without `PE_SAT_EN`: `acc_out`=0, `ovf`=0.

Source files
------------

// File: rtl/pe_mac.sv
// pe_mac: signed multiply-accumulate processing element.
// Each accepted beat picks one of three feature sources (or zero), multiplies
// it by a signed weight and folds the product into a window of TAPS products.
// One result per window is presented on acc_out with a one-cycle out_valid.
// Build option: define PE_SAT_EN to saturate the accumulator and report
// clamping on ovf; without it the accumulator wraps and ovf stays 0.
module pe_mac #(
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int AW   = 20,
  parameter int TAPS = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [1:0]    control,
  input  logic [DW-1:0] fi,
  input  logic [DW-1:0] fot,
  input  logic [DW-1:0] frv,
  input  logic [WW-1:0] wi,
  output logic [AW-1:0] acc_out,
  output logic          out_valid,
  output logic          ovf
);

  localparam int PW = DW + WW;
  localparam int SW = AW + 1;
  localparam int CW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CW-1:0] LAST_TAP = CW'(TAPS - 1);

  logic [CW-1:0] tapCnt_q, tapCnt_d;
  logic          accept, firstTap, lastTap;
  logic [DW-1:0] featSel;

  logic [DW-1:0] feat_q;
  logic [WW-1:0] wt_q;
  logic          v1_q, first1_q, last1_q;

  logic [PW-1:0] featExt, wtExt, prod_d;
  logic [PW-1:0] prod_q;
  logic          v2_q, first2_q, last2_q;

  logic [AW-1:0] acc_q, acc_d;
  logic          v3_q, last3_q;

  logic [AW-1:0] accOut_q;
  logic          outValid_q;

  assign accept   = in_valid & en & ~clear;
  assign firstTap = (tapCnt_q == '0);
  assign lastTap  = (tapCnt_q == LAST_TAP);

  // Route the selected feature source; select 0 still occupies a tap as a zero.
  always_comb begin
    featSel = '0;
    case (control)
      2'd1:    featSel = fi;
      2'd2:    featSel = fot;
      2'd3:    featSel = frv;
      default: featSel = '0;
    endcase
  end

  // Advance the tap position on every accepted beat, wrapping after the last tap.
  always_comb begin
    tapCnt_d = tapCnt_q;
    if (accept) begin
      tapCnt_d = lastTap ? '0 : tapCnt_q + 1'b1;
    end
  end

  // Stage 1: capture the beat together with its window position flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tapCnt_q <= '0;
      feat_q   <= '0;
      wt_q     <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else if (clear) begin
      tapCnt_q <= '0;
      v1_q     <= 1'b0;
    end else if (en) begin
      tapCnt_q <= tapCnt_d;
      v1_q     <= in_valid;
      feat_q   <= featSel;
      wt_q     <= wi;
      first1_q <= firstTap;
      last1_q  <= lastTap;
    end
  end

  // Both operands are sign-extended to the product width so the low PW bits
  // of the multiply are the exact signed product.
  assign featExt = PW'($signed(feat_q));
  assign wtExt   = PW'($signed(wt_q));
  assign prod_d  = featExt * wtExt;

  // Stage 2: register the full-precision product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_q   <= '0;
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
    end else if (clear) begin
      v2_q <= 1'b0;
    end else if (en) begin
      prod_q   <= prod_d;
      v2_q     <= v1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
    end
  end

`ifdef PE_SAT_EN
  logic [SW-1:0] prodExt, accExt, sumFull;
  logic          clampHi, clampLo;
  logic          sticky_q, sticky_d;
  logic          ovf_q;

  // One guard bit above the accumulator exposes any excursion out of range,
  // which is then clamped to the nearest representable extreme.
  always_comb begin
    prodExt  = SW'($signed(prod_q));
    accExt   = SW'($signed(acc_q));
    sumFull  = first2_q ? prodExt : accExt + prodExt;
    clampHi  = ~sumFull[AW] & sumFull[AW-1];
    clampLo  = sumFull[AW] & ~sumFull[AW-1];
    acc_d    = sumFull[AW-1:0];
    if (clampHi) begin
      acc_d = {1'b0, {(AW-1){1'b1}}};
    end else if (clampLo) begin
      acc_d = {1'b1, {(AW-1){1'b0}}};
    end
    sticky_d = (first2_q ? 1'b0 : sticky_q) | clampHi | clampLo;
  end

  // Remember whether any accumulation in the current window was clamped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_q <= 1'b0;
    end else if (clear) begin
      sticky_q <= 1'b0;
    end else if (en && v2_q) begin
      sticky_q <= sticky_d;
    end
  end

  // Publish the window's overflow status alongside its result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
    end else if (!clear && en && v3_q && last3_q) begin
      ovf_q <= sticky_q;
    end
  end

  assign ovf = ovf_q;
`else
  logic [AW-1:0] prodExtW;

  // Without saturation the accumulator simply wraps modulo 2^AW.
  always_comb begin
    prodExtW = AW'($signed(prod_q));
    acc_d    = first2_q ? prodExtW : acc_q + prodExtW;
  end

  assign ovf = 1'b0;
`endif

  // Stage 3: accumulate; the first tap of a window reloads instead of adding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q   <= '0;
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
    end else if (clear) begin
      acc_q   <= '0;
      v3_q    <= 1'b0;
      last3_q <= 1'b0;
    end else if (en) begin
      v3_q    <= v2_q;
      last3_q <= last2_q;
      if (v2_q) begin
        acc_q <= acc_d;
      end
    end
  end

  // Present the completed window sum for one enabled cycle; a flush keeps the
  // last published value visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accOut_q   <= '0;
      outValid_q <= 1'b0;
    end else if (clear) begin
      outValid_q <= 1'b0;
    end else if (en) begin
      outValid_q <= v3_q & last3_q;
      if (v3_q && last3_q) begin
        accOut_q <= acc_q;
      end
    end
  end

  assign acc_out   = accOut_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_pe_mac.sv
// Testbench for pe_mac: two instances (TAPS=4/AW=16 and TAPS=1/AW=20) share
// the stimulus and are checked every cycle against a window-level model.
module tb_pe_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        clear;
  logic        inValid;
  logic [1:0]  control;
  logic [7:0]  fi, fot, frv, wi;
  logic [15:0] accOut0;
  logic [19:0] accOut1;
  logic        outValid0, outValid1, ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  localparam int SCHED = 8192;

  int     tapsM[2] = '{4, 1};
  int     awM[2]   = '{16, 20};
  int     cntM[2];
  longint accM[2];
  bit     stickyM[2];
  bit     expValid[2];
  longint expAcc[2];
  bit     expOvf[2];
  bit     schedV[2][SCHED];
  longint schedVal[2][SCHED];
  bit     schedOvf[2][SCHED];
  int     enCnt = 0;

  pe_mac #(.DW(8), .WW(8), .AW(16), .TAPS(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in_valid(inValid),
    .control(control), .fi(fi), .fot(fot), .frv(frv), .wi(wi),
    .acc_out(accOut0), .out_valid(outValid0), .ovf(ovf0)
  );

  pe_mac #(.DW(8), .WW(8), .AW(20), .TAPS(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .in_valid(inValid),
    .control(control), .fi(fi), .fot(fot), .frv(frv), .wi(wi),
    .acc_out(accOut1), .out_valid(outValid1), .ovf(ovf1)
  );

  always #5 clk = ~clk;

  function automatic longint wrapAw(longint x, int aw);
    longint m = longint'(1) << aw;
    longint r = x % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic wipeSchedule(int i);
    for (int k = 0; k < SCHED; k++) schedV[i][k] = 1'b0;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      cntM[i] = 0; accM[i] = 0; stickyM[i] = 1'b0;
      expValid[i] = 1'b0; expAcc[i] = 0; expOvf[i] = 1'b0;
      wipeSchedule(i);
    end
  endtask

  // Window-level reference: each accepted beat's product is folded into the
  // running window; a completed window is due 3 enabled edges later.
  task automatic modelEdge();
    longint f, p, hi, lo;
    if (!rst) begin
      modelReset();
      return;
    end
    if (clear) begin
      for (int i = 0; i < 2; i++) begin
        cntM[i] = 0; accM[i] = 0; stickyM[i] = 1'b0; expValid[i] = 1'b0;
        wipeSchedule(i);
      end
      return;
    end
    if (!en) return;
    enCnt++;
    case (control)
      2'd1:    f = longint'($signed(fi));
      2'd2:    f = longint'($signed(fot));
      2'd3:    f = longint'($signed(frv));
      default: f = 0;
    endcase
    p = f * longint'($signed(wi));
    for (int i = 0; i < 2; i++) begin
      if (schedV[i][enCnt]) begin
        expValid[i] = 1'b1;
        expAcc[i]   = schedVal[i][enCnt];
        expOvf[i]   = schedOvf[i][enCnt];
      end else begin
        expValid[i] = 1'b0;
      end
      if (inValid) begin
        hi = (longint'(1) << (awM[i] - 1)) - 1;
        lo = -(longint'(1) << (awM[i] - 1));
        if (cntM[i] == 0) begin
          accM[i] = p; stickyM[i] = 1'b0;
        end else begin
          accM[i] = accM[i] + p;
        end
`ifdef PE_SAT_EN
        if (accM[i] > hi) begin accM[i] = hi; stickyM[i] = 1'b1; end
        if (accM[i] < lo) begin accM[i] = lo; stickyM[i] = 1'b1; end
`else
        accM[i] = wrapAw(accM[i], awM[i]);
`endif
        cntM[i]++;
        if (cntM[i] == tapsM[i]) begin
          cntM[i] = 0;
          if (enCnt + 3 < SCHED) begin
            schedV[i][enCnt + 3]   = 1'b1;
            schedVal[i][enCnt + 3] = accM[i];
`ifdef PE_SAT_EN
            schedOvf[i][enCnt + 3] = stickyM[i];
`else
            schedOvf[i][enCnt + 3] = 1'b0;
`endif
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_vld0"}, outValid0, expValid[0]);
    chk({tag, "_acc0"}, $signed(accOut0), expAcc[0]);
    chk({tag, "_ovf0"}, ovf0, expOvf[0]);
    chk({tag, "_vld1"}, outValid1, expValid[1]);
    chk({tag, "_acc1"}, $signed(accOut1), expAcc[1]);
    chk({tag, "_ovf1"}, ovf1, expOvf[1]);
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, check.
  task automatic applyStimulus(input string tag, input bit v, input int c, input int a,
                               input int b, input int d, input int w, input bit e, input bit clr);
    inValid = v; control = 2'(c); fi = 8'(a); fot = 8'(b); frv = 8'(d); wi = 8'(w);
    en = e; clear = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) applyStimulus(tag, 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  initial begin
    int pulses;
    rst = 1'b0; en = 1'b0; clear = 1'b0; inValid = 1'b0; control = '0;
    fi = '0; fot = '0; frv = '0; wi = '0;
    modelReset();

    // Reset and idle behaviour
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst");
    rst = 1'b1;
    idle("idle", 6);

    // Basic mixed-source window
    applyStimulus("basic", 1'b1, 1, 3, 0, 0, 2, 1'b1, 1'b0);
    applyStimulus("basic", 1'b1, 2, 0, -5, 0, 4, 1'b1, 1'b0);
    applyStimulus("basic", 1'b1, 3, 0, 0, 7, -1, 1'b1, 1'b0);
    applyStimulus("basic", 1'b1, 0, 11, 12, 13, 9, 1'b1, 1'b0);
    idle("basic", 2);
    chk("basic_early", outValid0, 1'b0);
    idle("basic", 1);
    chk("basic_valid", outValid0, 1'b1);
    chk("basic_value", $signed(accOut0), -21);
    chk("basic_ovf", ovf0, 1'b0);

    // Continuous stream of unit products
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus("stream", k < 12, 1, 1, 0, 0, 1, 1'b1, 1'b0);
      if (outValid0) pulses++;
    end
    chk("stream_pulses", pulses, 3);
    chk("stream_value", $signed(accOut0), 4);

    // Stall in the middle of a window
    pulses = 0;
    applyStimulus("stall", 1'b1, 1, 3, 0, 0, 2, 1'b1, 1'b0);
    applyStimulus("stall", 1'b1, 2, 0, -5, 0, 4, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus("stall", 1'b1, 1, 100, 0, 0, 100, 1'b0, 1'b0);
      if (outValid0 && en) pulses++;
    end
    applyStimulus("stall", 1'b1, 3, 0, 0, 7, -1, 1'b1, 1'b0);
    applyStimulus("stall", 1'b1, 0, 0, 0, 0, 9, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("stall", 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      if (outValid0 && en) pulses++;
    end
    chk("stall_value", $signed(accOut0), -21);
    chk("stall_pulses", pulses, 1);

    // Flush after a partial window
    applyStimulus("clear", 1'b1, 1, 50, 0, 0, 50, 1'b1, 1'b0);
    applyStimulus("clear", 1'b1, 1, 60, 0, 0, 60, 1'b1, 1'b0);
    applyStimulus("clear", 1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus("clear", 1'b1, 1, 2, 0, 0, 3, 1'b1, 1'b0);
    idle("clear", 3);
    chk("clear_value", $signed(accOut0), 24);
    chk("clear_valid", outValid0, 1'b1);

    // Overflow of a 16-bit accumulator
    for (int k = 0; k < 4; k++) applyStimulus("ovf", 1'b1, 1, -128, 0, 0, -128, 1'b1, 1'b0);
    idle("ovf", 3);
`ifdef PE_SAT_EN
    chk("ovf_value", $signed(accOut0), 32767);
    chk("ovf_flag", ovf0, 1'b1);
`else
    chk("ovf_value", $signed(accOut0), 0);
    chk("ovf_flag", ovf0, 1'b0);
`endif
    chk("ovf_taps1", $signed(accOut1), 16384);

    // Randomised traffic with stalls and occasional flushes
    for (int k = 0; k < 500; k++) begin
      applyStimulus("rand", $urandom_range(0, 3) != 0, int'($urandom_range(0, 3)),
                    int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                    $urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0);
    end
    idle("drain", 4);

    // Reset in the middle of a window
    applyStimulus("midrst", 1'b1, 1, 9, 0, 0, 9, 1'b1, 1'b0);
    applyStimulus("midrst", 1'b1, 1, 9, 0, 0, 9, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_async");
    applyStimulus("midrst", 1'b1, 1, 9, 0, 0, 9, 1'b1, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus("after", 1'b1, 2, 0, -3, 0, 5, 1'b1, 1'b0);
    idle("after", 3);
    chk("after_value", $signed(accOut0), -60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
